adder_carry_pipe_amisha: RTL
============================

Name: adder_carry_pipe_Amisha

Overview:
- Parametrised, pipelined successor to the 4-bit ripple adder with carry-out.
- Adds or subtracts two WIDTH-bit operands by splitting them into SEG-bit segments, one segment per pipeline stage; carry is registered between stages.
- Supports add/sub mode, carry-in, carry-out and signed overflow.
- Uses a valid/ready handshake on both sides, so it sits between a producer and a consumer in datapaths too wide for a single-cycle ripple.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG.
- SEG, 4, segment width per stage; NSEG = WIDTH/SEG pipeline stages, NSEG >= 1.

Ports:
- clk_amisha  in  1  clock, rising edge.
- rst_n_amisha  in  1  asynchronous active-low reset.
- in_valid_amisha  in  1  operands valid.
- in_ready_amisha  out  1  block can accept operands this cycle.
- a_amisha  in  WIDTH  operand A.
- b_amisha  in  WIDTH  operand B.
- sub_amisha  in  1  0 = A+B+cin, 1 = A-B.
- cin_amisha  in  1  carry-in; used in add mode only.
- out_valid_amisha  out  1  result valid.
- out_ready_amisha  in  1  consumer accepts result.
- sum_amisha  out  WIDTH  result, modulo 2^WIDTH.
- cout_amisha  out  1  carry-out; in sub mode 1 = no borrow (A >= B unsigned).
- ovf_amisha  out  1  signed two's-complement overflow.

Behaviour:
- Reset: asynchronous active-low, as already decided (clk_amisha, rst_n_amisha).
  - While rst_n_amisha = 0, all stage valid bits clear and all data registers clear.
  - out_valid_amisha = 0, sum_amisha = 0, cout_amisha = 0, ovf_amisha = 0.
  - in_ready_amisha = 1 once reset deasserts.
  - Reset mid-operation discards all in-flight operations; there is no partial output.
- Global advance enable: adv = !out_valid_amisha || out_ready_amisha.
  - in_ready_amisha = adv (combinational).
  - Accept occurs when in_valid_amisha && adv.
- When adv = 1, every stage shifts one position. Stage 0 loads the new operation, with valid = in_valid_amisha.
- When adv = 0, all stages hold, including bubbles. Bubbles are not collapsed.
- Mode and carry-in:
  - Effective B: beff = sub ? ~b : b.
  - Initial carry: c0 = sub ? 1 : cin_amisha.
  - cin_amisha is ignored in sub mode.
  - Both are captured at accept.
- Stage k (k = 0..NSEG-1):
  - Computes {c_k+1, s_k} = a[k] + beff[k] + c_k over SEG+1 bits and registers it.
  - Upper operand segments are skew-delayed, so segment k reaches stage k exactly k cycles after accept.
  - Lower result segments are deskew-delayed, so all segments align at the output.
- Final stage:
  - Also registers the carry into the MSB (bit WIDTH-1).
  - ovf = carry_into_MSB XOR carry_out.
  - cout = carry_out.
- Latency: a result accepted at edge T has out_valid_amisha = 1 after edge T+NSEG-1, i.e. NSEG cycles of pipeline with no stall.
  - NSEG = 1 is a registered single-cycle adder with latency 1.
- Throughput: one operation per cycle while out_ready_amisha = 1.
- Output hold: out_valid_amisha, sum_amisha, cout_amisha and ovf_amisha hold stable while out_valid_amisha = 1 && out_ready_amisha = 0.
- Simultaneous output handshake and new accept in the same cycle is legal: the pipeline shifts and no data is lost or duplicated.
- Ordering: results leave in accept order. Operations are never dropped or reordered.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is reported only through cout_amisha and ovf_amisha.

Decomposition:
- Shared package/header adder_pkg_Amisha holds:
  - the MODE_ADD = 1'b0 and MODE_SUB = 1'b1 constants;
  - the NSEG derivation macro or function;
  - the WIDTH % SEG == 0 elaboration check.
- One sub-module, adder_seg_Amisha: registered SEG-bit segment adder.
  - Inputs: a_seg, b_seg, c_in, en, valid_in.
  - Outputs: s_seg, c_out, c_msb, valid_out.
  - It is instantiated NSEG times via generate.
- Skew and deskew delay lines stay in the top module.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Carry ripple across all segments: add 0xFFFF + 0x0001, cin=0, out_ready held 1 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
- Signed overflow: add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Also add 0x000F + 0x0000 with cin=1 -> sum=0x0010, cout=0, ovf=0.
- Subtract with borrow: sub 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back operations (i, i*0x1111) while out_ready is low for cycles 5-9.
  - in_ready drops while the output is stalled.
  - Outputs stay stable while stalled.
  - All 8 results match the reference model in order, with no duplicates.
- Reset mid-stream: assert rst_n low asynchronously with 3 operations in flight -> out_valid and all outputs go to 0 immediately. After release, the next operation 0x1234 + 0x1111 returns 0x2345 at latency 4.
- Parameter sweep: rerun the first two scenarios with SEG=16 (NSEG=1, latency 1) and WIDTH=32, SEG=8, checking the same cout/ovf rules.

Source files
------------

// File: rtl/adder_carry_pipe_amisha_pkg.sv
// -----------------------------------------------------------------------------
// adder_carry_pipe_amisha_pkg
// Shared definitions for the segmented, pipelined carry adder:
//   - MODE_ADD / MODE_SUB : values of the sub_amisha mode input
//   - seg_count()         : number of pipeline stages for a WIDTH/SEG pair
//   - seg_params_ok()     : legality of a WIDTH/SEG pair, checked at elaboration
// -----------------------------------------------------------------------------
package adder_carry_pipe_amisha_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Guarded so that an illegal SEG of zero still elaborates far enough to
    // reach the parameter check instead of dividing by zero.
    function automatic int seg_count(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 1;
    endfunction

    function automatic bit seg_params_ok(input int width, input int seg);
        return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/adder_carry_pipe_amisha_seg.sv
// -----------------------------------------------------------------------------
// adder_carry_pipe_amisha_seg
// One registered SEG-bit slice of the pipelined adder.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   en          : pipeline advance; all registers hold while low
//   valid_in    : stage-valid bit travelling with the operands
//   a_seg,b_seg : operand slices (b_seg already inverted for subtraction)
//   c_in        : carry from the previous slice (or the initial carry)
//   s_seg       : registered slice sum
//   c_out       : registered carry out of the slice
//   c_msb       : registered carry into the slice's top bit
//   valid_out   : registered stage-valid bit
// -----------------------------------------------------------------------------
module adder_carry_pipe_amisha_seg #(
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           valid_in,
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           c_in,
    output logic [SEG-1:0] s_seg,
    output logic           c_out,
    output logic           c_msb,
    output logic           valid_out
);

    logic [SEG:0] seg_sum;
    logic         msb_carry_d;

    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out of
    // the sum already computed without a second, narrower adder.
    assign msb_carry_d = a_seg[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1];

    // NOTE: non-blocking assignments here so every stage samples its
    // neighbours' pre-edge values; blocking would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg     <= '0;
            c_out     <= 1'b0;
            c_msb     <= 1'b0;
            valid_out <= 1'b0;
        end else if (en) begin
            s_seg     <= seg_sum[SEG-1:0];
            c_out     <= seg_sum[SEG];
            c_msb     <= msb_carry_d;
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/adder_carry_pipe_amisha.sv
// -----------------------------------------------------------------------------
// adder_carry_pipe_amisha
// WIDTH-bit add/subtract split into NSEG = WIDTH/SEG registered slices, one
// per pipeline stage, with valid/ready handshakes on both sides. The whole
// pipeline advances together whenever the output is empty or being taken.
//   clk_amisha, rst_n_amisha : clock (rising edge), async active-low reset
//   in_valid_amisha          : operands valid
//   in_ready_amisha          : operands accepted this cycle if valid
//   a_amisha, b_amisha       : operands
//   sub_amisha               : MODE_ADD -> A+B+cin, MODE_SUB -> A-B
//   cin_amisha               : carry-in, add mode only
//   out_valid_amisha         : result valid
//   out_ready_amisha         : consumer takes the result
//   sum_amisha               : result modulo 2^WIDTH
//   cout_amisha              : carry-out (sub mode: 1 = no borrow)
//   ovf_amisha               : signed two's-complement overflow
// -----------------------------------------------------------------------------
module adder_carry_pipe_amisha
    import adder_carry_pipe_amisha_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             in_valid_amisha,
    output logic             in_ready_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [WIDTH-1:0] b_amisha,
    input  logic             sub_amisha,
    input  logic             cin_amisha,
    output logic             out_valid_amisha,
    input  logic             out_ready_amisha,
    output logic [WIDTH-1:0] sum_amisha,
    output logic             cout_amisha,
    output logic             ovf_amisha
);

    localparam int NSEG = seg_count(WIDTH, SEG);

    if (!seg_params_ok(WIDTH, SEG)) begin : g_param_check
        $error("adder_carry_pipe_amisha: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)",
               WIDTH, SEG);
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [NSEG:0]    carry_chain;
    logic [NSEG:0]    valid_chain;
    logic [NSEG-1:0]  msb_carry;

    // One enable for every stage: bubbles are kept rather than squeezed out,
    // which keeps ordering and skew alignment trivial.
    assign adv             = !out_valid_amisha || out_ready_amisha;
    assign in_ready_amisha = adv;

    assign b_eff = (sub_amisha == MODE_SUB) ? ~b_amisha : b_amisha;
    assign c0    = (sub_amisha == MODE_SUB) ? 1'b1 : cin_amisha;

    assign carry_chain[0] = c0;
    assign valid_chain[0] = in_valid_amisha;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        // REM: operand bits still to be consumed at this stage's input, with
        //      this stage's slice at the bottom.
        // RES: result bits settled once this stage has registered.
        localparam int REM = (NSEG - k) * SEG;
        localparam int RES = (k + 1) * SEG;

        logic [REM-1:0] a_rem;
        logic [REM-1:0] b_rem;
        logic [SEG-1:0] s_seg;
        logic [RES-1:0] res;

        if (k == 0) begin : g_head
            assign a_rem = a_amisha;
            assign b_rem = b_eff;
            assign res   = s_seg;
        end else begin : g_body
            logic [REM-1:0]     a_skew_q;
            logic [REM-1:0]     b_skew_q;
            logic [k*SEG-1:0]   low_q;

            // Upper operand slices ride alongside the previous stage so they
            // meet its carry here; lower result slices are carried forward so
            // every slice of one operation lines up at the output.
            // NOTE: data registers are reset too, not just the valid bits,
            // because sum/cout/ovf must read zero while reset is asserted.
            always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
                if (!rst_n_amisha) begin
                    a_skew_q <= '0;
                    b_skew_q <= '0;
                    low_q    <= '0;
                end else if (adv) begin
                    a_skew_q <= g_stage[k-1].a_rem[REM+SEG-1:SEG];
                    b_skew_q <= g_stage[k-1].b_rem[REM+SEG-1:SEG];
                    low_q    <= g_stage[k-1].res;
                end
            end

            assign a_rem = a_skew_q;
            assign b_rem = b_skew_q;
            assign res   = {s_seg, low_q};
        end

        adder_carry_pipe_amisha_seg #(
            .SEG (SEG)
        ) u_seg (
            .clk       (clk_amisha),
            .rst_n     (rst_n_amisha),
            .en        (adv),
            .valid_in  (valid_chain[k]),
            .a_seg     (a_rem[SEG-1:0]),
            .b_seg     (b_rem[SEG-1:0]),
            .c_in      (carry_chain[k]),
            .s_seg     (s_seg),
            .c_out     (carry_chain[k+1]),
            .c_msb     (msb_carry[k]),
            .valid_out (valid_chain[k+1])
        );
    end

    // Only the last slice's MSB carry feeds the overflow flag; the others
    // exist because every slice is the same module.
    logic unused_msb_carry;
    assign unused_msb_carry = ^msb_carry[NSEG-1:0];

    assign out_valid_amisha = valid_chain[NSEG];
    assign sum_amisha       = g_stage[NSEG-1].res;
    assign cout_amisha      = carry_chain[NSEG];
    assign ovf_amisha       = msb_carry[NSEG-1] ^ carry_chain[NSEG];

endmodule
